// File: rtl/spi_regfile_arbiter.sv
// ============================================================================
// Module   : spi_regfile_arbiter
// Purpose  : Serializes register-file accesses from an SPI slave front end
//            (four-phase level handshake, already in the i_clk domain) and
//            from the core (req / one-cycle ack pulse) onto the single
//            read/write port of a register file. A three-state sequencer
//            (IDLE -> ACCESS -> CAPTURE) gives one access every three cycles.
// Options  : SPI_ARB_RR_EN - when defined, contention is resolved round-robin
//            using a 1-bit last-winner pointer; otherwise SPI always wins.
// Ports    :
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_spi_req/we/addr/wdata       SPI command (level request)
//   o_spi_ack, o_spi_rdata        SPI acknowledge level and read data
//   i_core_req/we/addr/wdata      core command (held until ack pulse)
//   o_core_ack, o_core_rdata      core completion pulse and read data
//   o_rf_en/we/addr/wdata         register-file port strobe and command
//   i_rf_rdata                    register-file read data (cycle after en)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_regfile_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_spi_req,
    input  logic              i_spi_we,
    input  logic [ADDR_W-1:0] i_spi_addr,
    input  logic [DATA_W-1:0] i_spi_wdata,
    output logic              o_spi_ack,
    output logic [DATA_W-1:0] o_spi_rdata,
    input  logic              i_core_req,
    input  logic              i_core_we,
    input  logic [ADDR_W-1:0] i_core_addr,
    input  logic [DATA_W-1:0] i_core_wdata,
    output logic              o_core_ack,
    output logic [DATA_W-1:0] o_core_rdata,
    output logic              o_rf_en,
    output logic              o_rf_we,
    output logic [ADDR_W-1:0] o_rf_addr,
    output logic [DATA_W-1:0] o_rf_wdata,
    input  logic [DATA_W-1:0] i_rf_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam logic [1:0] c_GNT_NONE = 2'b00;
    localparam logic [1:0] c_GNT_SPI  = 2'b01;
    localparam logic [1:0] c_GNT_CORE = 2'b10;

    state_t              r_state,        w_state_nxt;
    logic [1:0]          r_gnt,          w_gnt_nxt;
    logic                r_spi_ack,      w_spi_ack_nxt;
    logic [DATA_W-1:0]   r_spi_rdata,    w_spi_rdata_nxt;
    logic                r_core_ack,     w_core_ack_nxt;
    logic [DATA_W-1:0]   r_core_rdata,   w_core_rdata_nxt;
    logic                r_rf_en,        w_rf_en_nxt;
    logic                r_rf_we,        w_rf_we_nxt;
    logic [ADDR_W-1:0]   r_rf_addr,      w_rf_addr_nxt;
    logic [DATA_W-1:0]   r_rf_wdata,     w_rf_wdata_nxt;

    logic w_spi_elig;
    logic w_core_elig;
    logic w_pick_spi;
    logic w_pick_core;

    // A requester whose ack is still showing has already been served; masking
    // it here prevents a held SPI level or a core req lingering in its ack
    // cycle from being granted twice.
    assign w_spi_elig  = i_spi_req  & ~r_spi_ack;
    assign w_core_elig = i_core_req & ~r_core_ack;

`ifdef SPI_ARB_RR_EN
    // 1 = core won the most recent grant, 0 = SPI won it.
    logic r_last_core;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_core <= 1'b0;
        end else if ((r_state == ST_IDLE) && (w_pick_spi | w_pick_core)) begin
            r_last_core <= w_pick_core;
        end
    end

    // Under contention the side that did not win last time goes first.
    assign w_pick_spi = w_spi_elig & (~w_core_elig | r_last_core);
`else
    assign w_pick_spi = w_spi_elig;
`endif

    assign w_pick_core = w_core_elig & ~w_pick_spi;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_gnt        <= c_GNT_NONE;
            r_spi_ack    <= 1'b0;
            r_spi_rdata  <= '0;
            r_core_ack   <= 1'b0;
            r_core_rdata <= '0;
            r_rf_en      <= 1'b0;
            r_rf_we      <= 1'b0;
            r_rf_addr    <= '0;
            r_rf_wdata   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_gnt        <= w_gnt_nxt;
            r_spi_ack    <= w_spi_ack_nxt;
            r_spi_rdata  <= w_spi_rdata_nxt;
            r_core_ack   <= w_core_ack_nxt;
            r_core_rdata <= w_core_rdata_nxt;
            r_rf_en      <= w_rf_en_nxt;
            r_rf_we      <= w_rf_we_nxt;
            r_rf_addr    <= w_rf_addr_nxt;
            r_rf_wdata   <= w_rf_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_gnt_nxt        = r_gnt;
        w_rf_en_nxt      = 1'b0;
        w_rf_we_nxt      = r_rf_we;
        w_rf_addr_nxt    = r_rf_addr;
        w_rf_wdata_nxt   = r_rf_wdata;
        w_spi_rdata_nxt  = r_spi_rdata;
        w_core_rdata_nxt = r_core_rdata;
        w_core_ack_nxt   = 1'b0;
        // SPI ack release runs beside the sequencer: it drops on the edge
        // that samples the request low, whatever the FSM is doing.
        w_spi_ack_nxt    = r_spi_ack & i_spi_req;

        case (r_state)
            ST_IDLE: begin
                if (w_pick_spi) begin
                    w_gnt_nxt      = c_GNT_SPI;
                    w_rf_en_nxt    = 1'b1;
                    w_rf_we_nxt    = i_spi_we;
                    w_rf_addr_nxt  = i_spi_addr;
                    w_rf_wdata_nxt = i_spi_wdata;
                    w_state_nxt    = ST_ACCESS;
                end else if (w_pick_core) begin
                    w_gnt_nxt      = c_GNT_CORE;
                    w_rf_en_nxt    = 1'b1;
                    w_rf_we_nxt    = i_core_we;
                    w_rf_addr_nxt  = i_core_addr;
                    w_rf_wdata_nxt = i_core_wdata;
                    w_state_nxt    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // Read data from the register file is valid in this cycle.
                if (r_gnt == c_GNT_SPI) begin
                    w_spi_ack_nxt = 1'b1;
                    if (!r_rf_we) begin
                        w_spi_rdata_nxt = i_rf_rdata;
                    end
                end else if (r_gnt == c_GNT_CORE) begin
                    w_core_ack_nxt = 1'b1;
                    if (!r_rf_we) begin
                        w_core_rdata_nxt = i_rf_rdata;
                    end
                end
                w_gnt_nxt   = c_GNT_NONE;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_gnt_nxt   = c_GNT_NONE;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_spi_ack    = r_spi_ack;
    assign o_spi_rdata  = r_spi_rdata;
    assign o_core_ack   = r_core_ack;
    assign o_core_rdata = r_core_rdata;
    assign o_rf_en      = r_rf_en;
    assign o_rf_we      = r_rf_we;
    assign o_rf_addr    = r_rf_addr;
    assign o_rf_wdata   = r_rf_wdata;

endmodule

`default_nettype wire

// File: tb/tb_spi_regfile_arbiter.sv
// ============================================================================
// Module   : tb_spi_regfile_arbiter
// Purpose  : Self-checking bench for spi_regfile_arbiter. Requester drivers
//            queue each command as they raise it; a monitor keeps a
//            transaction-level model (busy phase, eligibility, winner rule,
//            reference memory, ack levels) and compares the DUT every cycle.
//            A behavioural register file answers reads one cycle after o_rf_en.
// Options  : SPI_ARB_RR_EN - selects the round-robin winner rule in the model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_regfile_arbiter;

    typedef struct packed {
        logic       we;
        logic [6:0] addr;
        logic [7:0] wdata;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_req = 1'b0, spi_we = 1'b0;
    logic [6:0] spi_addr = '0;
    logic [7:0] spi_wdata = '0;
    logic       core_req = 1'b0, core_we = 1'b0;
    logic [6:0] core_addr = '0;
    logic [7:0] core_wdata = '0;
    logic [7:0] rf_rdata;
    logic       o_spi_ack, o_core_ack, o_rf_en, o_rf_we;
    logic [7:0] o_spi_rdata, o_core_rdata, o_rf_wdata;
    logic [6:0] o_rf_addr;

    int n_checks = 0;
    int n_pass   = 0;

    txn_t spi_q[$];
    txn_t core_q[$];

    always #5 clk = ~clk;

    spi_regfile_arbiter #(.ADDR_W(7), .DATA_W(8)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_spi_req(spi_req), .i_spi_we(spi_we), .i_spi_addr(spi_addr), .i_spi_wdata(spi_wdata),
        .o_spi_ack(o_spi_ack), .o_spi_rdata(o_spi_rdata),
        .i_core_req(core_req), .i_core_we(core_we), .i_core_addr(core_addr), .i_core_wdata(core_wdata),
        .o_core_ack(o_core_ack), .o_core_rdata(o_core_rdata),
        .o_rf_en(o_rf_en), .o_rf_we(o_rf_we), .o_rf_addr(o_rf_addr), .o_rf_wdata(o_rf_wdata),
        .i_rf_rdata(rf_rdata)
    );

    function automatic logic [7:0] init_val(input int i);
        return 8'(i * 29 + 5);
    endfunction

    // Behavioural register file seen by the DUT.
    logic [7:0] rf_mem [128];
    always @(posedge clk) begin
        if (rst) begin
            rf_rdata <= '0;
            for (int i = 0; i < 128; i++) rf_mem[i] <= init_val(i);
        end else if (o_rf_en) begin
            rf_rdata <= rf_mem[o_rf_addr];
            if (o_rf_we) rf_mem[o_rf_addr] <= o_rf_wdata;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model and monitor
    // ------------------------------------------------------------------
    int         m_phase;          // 0 idle, 1 access, 2 capture
    logic       m_owner_core, m_last_core, m_pend_we, m_prev_valid;
    logic       m_spi_ack, m_core_ack, m_exp_en, m_win_core;
    logic       n_spi_ack, n_core_ack;
    logic [7:0] m_spi_rdata, m_core_rdata, m_pend_rdata;
    logic       p_spi_e, p_core_e, p_spi_req;
    logic [7:0] ref_mem [128];
    txn_t       m_t;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) begin
                m_phase = 0; m_spi_ack = 0; m_core_ack = 0; m_last_core = 0;
                m_spi_rdata = 0; m_core_rdata = 0; m_prev_valid = 0;
                m_owner_core = 0; m_pend_we = 0; m_pend_rdata = 0;
                for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
            end else begin
                if (m_prev_valid) begin
                    m_exp_en = (m_phase == 0) && (p_spi_e || p_core_e);
                    chk("rf_en", 64'(o_rf_en), 64'(m_exp_en));
                    n_core_ack = (m_phase == 2) && m_owner_core;
                    n_spi_ack  = ((m_phase == 2) && !m_owner_core) || (m_spi_ack && p_spi_req);
                    if (m_phase == 2 && !m_pend_we) begin
                        if (m_owner_core) m_core_rdata = m_pend_rdata;
                        else              m_spi_rdata  = m_pend_rdata;
                    end
                    case (m_phase)
                        0: if (m_exp_en) begin
`ifdef SPI_ARB_RR_EN
                            if (p_spi_e && p_core_e) m_win_core = !m_last_core;
                            else                     m_win_core = p_core_e;
`else
                            m_win_core = !p_spi_e;
`endif
                            m_owner_core = m_win_core;
                            m_last_core  = m_win_core;
                            if ((m_win_core && core_q.size() == 0) || (!m_win_core && spi_q.size() == 0)) begin
                                timeout_fail("grant_without_pending_txn");
                            end else begin
                                m_t = m_win_core ? core_q.pop_front() : spi_q.pop_front();
                                chk(m_win_core ? "rf_cmd_core" : "rf_cmd_spi",
                                    64'({o_rf_we, o_rf_addr, o_rf_wdata}), 64'({m_t.we, m_t.addr, m_t.wdata}));
                                m_pend_we = m_t.we;
                                if (m_t.we) ref_mem[m_t.addr] = m_t.wdata;
                                else        m_pend_rdata = ref_mem[m_t.addr];
                            end
                            m_phase = 1;
                        end
                        1:       m_phase = 2;
                        default: m_phase = 0;
                    endcase
                    m_spi_ack  = n_spi_ack;
                    m_core_ack = n_core_ack;
                    chk("spi_ack",    64'(o_spi_ack),    64'(m_spi_ack));
                    chk("core_ack",   64'(o_core_ack),   64'(m_core_ack));
                    chk("spi_rdata",  64'(o_spi_rdata),  64'(m_spi_rdata));
                    chk("core_rdata", 64'(o_core_rdata), 64'(m_core_rdata));
                end
                p_spi_e      = spi_req  && !m_spi_ack;
                p_core_e     = core_req && !m_core_ack;
                p_spi_req    = spi_req;
                m_prev_valid = 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------
    task automatic spi_txn(input logic we, input logic [6:0] addr, input logic [7:0] wdata, input int hold);
        txn_t t;
        int   n;
        @(posedge clk); #1;
        spi_we = we; spi_addr = addr; spi_wdata = wdata; spi_req = 1'b1;
        t.we = we; t.addr = addr; t.wdata = wdata;
        spi_q.push_back(t);
        n = 0;
        while (!o_spi_ack && n < 100) begin @(posedge clk); #1; n++; end
        if (!o_spi_ack) timeout_fail("spi_ack_rise");
        repeat (hold) begin @(posedge clk); #1; end
        spi_req = 1'b0;
        n = 0;
        while (o_spi_ack && n < 100) begin @(posedge clk); #1; n++; end
        if (o_spi_ack) timeout_fail("spi_ack_fall");
    endtask

    task automatic core_txn(input logic we, input logic [6:0] addr, input logic [7:0] wdata, input bit hold_through);
        txn_t t;
        int   n;
        @(posedge clk); #1;
        core_we = we; core_addr = addr; core_wdata = wdata; core_req = 1'b1;
        t.we = we; t.addr = addr; t.wdata = wdata;
        core_q.push_back(t);
        n = 0;
        while (!o_core_ack && n < 100) begin @(posedge clk); #1; n++; end
        if (!o_core_ack) timeout_fail("core_ack_pulse");
        // Optionally keep req high across the ack cycle; it must be masked.
        if (hold_through) begin @(posedge clk); #1; end
        core_req = 1'b0;
    endtask

    task automatic reset_mid_access();
        txn_t t;
        int   n;
        @(posedge clk); #1;
        spi_we = 1'b0; spi_addr = 7'h22; spi_wdata = 8'h00; spi_req = 1'b1;
        t.we = 1'b0; t.addr = 7'h22; t.wdata = 8'h00;
        spi_q.push_back(t);
        n = 0;
        while (!o_rf_en && n < 20) begin @(posedge clk); #1; n++; end
        if (!o_rf_en) timeout_fail("reset_test_grant");
        rst = 1'b1;
        #1;
        chk("abort_ctl", 64'({o_spi_ack, o_core_ack, o_rf_en, o_rf_we}), 64'(0));
        chk("abort_bus", 64'({o_spi_rdata, o_core_rdata, o_rf_addr, o_rf_wdata}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        while (!o_spi_ack && n < 20) begin @(posedge clk); #1; n++; end
        if (!o_spi_ack) timeout_fail("reset_test_regrant");
        spi_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stimulus
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctl", 64'({o_spi_ack, o_core_ack, o_rf_en, o_rf_we}), 64'(0));
        chk("reset_bus", 64'({o_spi_rdata, o_core_rdata, o_rf_addr, o_rf_wdata}), 64'(0));
        rst = 1'b0;

        spi_txn(1'b1, 7'h15, 8'hA5, 0);        // SPI write
        core_txn(1'b0, 7'h03, 8'h00, 1'b1);    // core read, req held through ack
        spi_txn(1'b0, 7'h15, 8'h11, 1);        // SPI read-back of the write

        // Simultaneous contention; last grant was SPI.
        fork
            spi_txn(1'b1, 7'h40, 8'h3C, 0);
            core_txn(1'b0, 7'h15, 8'h77, 1'b0);
        join

        // SPI holds its request (and ack) while the core reads 0x7F.
        fork
            spi_txn(1'b0, 7'h10, 8'h00, 10);
            begin
                repeat (4) @(posedge clk);
                core_txn(1'b0, 7'h7F, 8'h00, 1'b1);
            end
        join

        reset_mid_access();

        // Randomized traffic from both sides.
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                    spi_txn(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), $urandom_range(0, 3));
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                    core_txn(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
                end
            end
        join

        repeat (6) @(posedge clk);
        #1;
        chk("queues_drained", 64'(spi_q.size() + core_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
